svv_traffic_gen: RTL and testbench
==================================

Name: svv_traffic_gen

Overview:
Synthesizable stimulus initiator that drives the push/pull/set side of a status-value-vector FIFO and never breaks its usage rules. It never pushes when the FIFO is full without a same-cycle pull. It never pulls or sets when the FIFO is empty. It runs a fixed phase sequence: fill, drain, LFSR-randomised mixed traffic, flush. It tracks FIFO occupancy with an internal shadow counter and can optionally cross-check the FIFO's valid/full status against it.

Parameters:
DEPTH, 8, FIFO entries mirrored by the shadow occupancy counter (power of two, >=2)
WIDTH, 8, data width of value_o/set_value_o
NUM_OPS, 64, cycles spent in the MIXED phase (>=1)
SEED, 16'hACE1, LFSR load value on start (must be nonzero)

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  asynchronous active-low reset
start_i  in  1  begin a run; sampled only in IDLE
full_i  in  1  FIFO full status
valid_i  in  1  FIFO non-empty status
push_o  out  1  push request to FIFO
pull_o  out  1  pull request to FIFO
set_o  out  1  re-update-last-entry request to FIFO
value_o  out  WIDTH  push data
set_value_o  out  WIDTH  re-update data
occupancy_o  out  $clog2(DEPTH)+1  shadow occupancy after all issued ops are applied
busy_o  out  1  run in progress (state != IDLE)
done_o  out  1  one-cycle pulse at end of run
error_o  out  1  sticky status mismatch (optional feature)

Behaviour:
- Reset: async on rsn_i low. State goes to IDLE. All outputs are 0, including occupancy_o, push counter wr_cnt and LFSR. Reset mid-run aborts immediately; the outputs drop without waiting for a clock.
- All outputs are registered. The FIFO consumes the ops presented in cycle n at edge n+1.
- occ (shown on occupancy_o) updates at the edge that registers the ops: occ_next = occ + push - pull. With push+pull at DEPTH, occ stays DEPTH.
- wr_cnt (WIDTH bits, wraps) increments on every issued push. value_o = wr_cnt when push_o=1, otherwise 0.
- set_value_o = ~(wr_cnt-1), the bitwise invert of the last pushed value, when set_o=1; otherwise 0.
- FSM:
  - IDLE: when start_i=1, load LFSR=SEED, clear op counter, go to FILL. start_i in any other state is ignored.
  - FILL: push_o=1 each cycle until occ reaches DEPTH (exactly DEPTH pushes from empty), then go to DRAIN.
  - DRAIN: pull_o=1 each cycle until occ reaches 0, then go to MIXED.
  - MIXED: runs NUM_OPS cycles. The LFSR advances every cycle; candidate {set,pull,push} = lfsr[2:0]. Mask in order:
    - pull forced 0 if occ==0.
    - set forced 0 if occ==0.
    - push forced 0 if occ==DEPTH and masked pull==0.
    - After NUM_OPS cycles, go to FLUSH.
  - FLUSH: pull_o=1 each cycle while occ>0, and zero cycles if occ is already 0. Then go to DONE.
  - DONE: done_o=1 for one cycle, all requests 0, then go to IDLE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left, feedback into bit 0.
- Same SEED gives a bit-identical output sequence on every run.
- Invariants in every state: never push_o with occ==DEPTH and pull_o==0; never pull_o or set_o with occ==0.

Optional Feature:
SVV_TG_CHECK_EN
- Defined: occ_q is occ delayed one cycle. Each cycle, a mismatch is detected if valid_i != (occ_q!=0) or full_i != (occ_q==DEPTH). A mismatch sets error_o at the next edge. error_o is sticky and is cleared by reset or by an accepted start_i.
- Undefined: no checker logic; error_o is tied to 0; full_i and valid_i are unused.

Test Plan:
1. Reset with DEPTH=8, WIDTH=8 -> every output 0; busy_o=0; occupancy_o=0.
2. One-cycle start_i -> push_o high for 8 cycles with value_o=0..7 and occupancy_o 1..8; then pull_o high for 8 cycles with occupancy_o 7..0; then MIXED begins.
3. Full run with NUM_OPS=64 -> no invariant violation on any cycle; occupancy_o stays within 0..8; FLUSH ends at 0; done_o pulses exactly once; busy_o falls the same cycle the state returns to IDLE.
4. SVV_TG_CHECK_EN, connected to the FIFO model -> error_o stays 0 for the whole run. Then force valid_i=0 while occ_q=3 -> error_o=1 on the next edge and stays 1 until the next start_i.
5. Assert rsn_i low mid-MIXED -> outputs go to 0 asynchronously. Release reset and start again -> push/pull/set/value sequence is identical to the first run.
6. Pulse start_i during FILL and during MIXED -> ignored; the phase sequence and cycle count are unchanged.

Source files
------------

// File: rtl/svv_traffic_gen.sv
// rtl/svv_traffic_gen.sv - rule-abiding push/pull/set initiator for a status-value-vector FIFO
// Optional status cross-check against the shadow occupancy enabled by `define SVV_TG_CHECK_EN.
module svv_traffic_gen #(
    parameter int          DEPTH   = 8,
    parameter int          WIDTH   = 8,
    parameter int          NUM_OPS = 64,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   start_i,
    input  logic                   full_i,
    input  logic                   valid_i,
    output logic                   push_o,
    output logic                   pull_o,
    output logic                   set_o,
    output logic [WIDTH-1:0]       value_o,
    output logic [WIDTH-1:0]       set_value_o,
    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(NUM_OPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_MIXED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
    logic               push_q, push_d;
    logic               pull_q, pull_d;
    logic               set_q, set_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH-1:0]   set_value_q, set_value_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [15:0]        lfsr_step;
    logic               occ_nz, occ_full;
    logic               mix_push, mix_pull, mix_set;

    assign occ_nz    = (occ_q != '0);
    assign occ_full  = (occ_q == OCC_W'(DEPTH));
    assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Mask order matters: push may proceed at full only if the masked pull frees a slot.
    assign mix_pull = lfsr_step[1] & occ_nz;
    assign mix_set  = lfsr_step[2] & occ_nz;
    assign mix_push = lfsr_step[0] & ~(occ_full & ~mix_pull);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        op_cnt_d = op_cnt_q;
        push_d   = 1'b0;
        pull_d   = 1'b0;
        set_d    = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_FILL;
                    lfsr_d   = SEED;
                    op_cnt_d = '0;
                    push_d   = 1'b1;
                end
            end
            S_FILL: begin
                if (!occ_full) begin
                    push_d = 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    pull_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (occ_nz) begin
                    pull_d = 1'b1;
                end else begin
                    state_d  = S_MIXED;
                    lfsr_d   = lfsr_step;
                    op_cnt_d = CNT_W'(1);
                    push_d   = mix_push;
                    pull_d   = mix_pull;
                    set_d    = mix_set;
                end
            end
            S_MIXED: begin
                if (op_cnt_q != CNT_W'(NUM_OPS)) begin
                    lfsr_d   = lfsr_step;
                    op_cnt_d = op_cnt_q + CNT_W'(1);
                    push_d   = mix_push;
                    pull_d   = mix_pull;
                    set_d    = mix_set;
                end else if (occ_nz) begin
                    state_d = S_FLUSH;
                    pull_d  = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                if (occ_nz) begin
                    pull_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counters and data follow the ops being registered this edge.
        occ_d       = occ_q + OCC_W'(push_d) - OCC_W'(pull_d);
        wr_cnt_d    = wr_cnt_q + WIDTH'(push_d);
        value_d     = push_d ? wr_cnt_q : '0;
        set_value_d = set_d ? ~(wr_cnt_d - WIDTH'(1)) : '0;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= S_IDLE;
            occ_q       <= '0;
            wr_cnt_q    <= '0;
            lfsr_q      <= '0;
            op_cnt_q    <= '0;
            push_q      <= 1'b0;
            pull_q      <= 1'b0;
            set_q       <= 1'b0;
            value_q     <= '0;
            set_value_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            wr_cnt_q    <= wr_cnt_d;
            lfsr_q      <= lfsr_d;
            op_cnt_q    <= op_cnt_d;
            push_q      <= push_d;
            pull_q      <= pull_d;
            set_q       <= set_d;
            value_q     <= value_d;
            set_value_q <= set_value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign push_o      = push_q;
    assign pull_o      = pull_q;
    assign set_o       = set_q;
    assign value_o     = value_q;
    assign set_value_o = set_value_q;
    assign occupancy_o = occ_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

`ifdef SVV_TG_CHECK_EN
    // The FIFO status lags the shadow count by one cycle, so compare against the delayed copy.
    logic [OCC_W-1:0] occ_dly_q, occ_dly_d;
    logic             error_q, error_d;
    logic             mismatch;

    always_comb begin
        occ_dly_d = occ_q;
        mismatch  = (valid_i != (occ_dly_q != '0)) || (full_i != (occ_dly_q == OCC_W'(DEPTH)));
        error_d   = (state_q == S_IDLE && start_i) ? 1'b0 : (error_q | mismatch);
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            occ_dly_q <= '0;
            error_q   <= 1'b0;
        end else begin
            occ_dly_q <= occ_dly_d;
            error_q   <= error_d;
        end
    end

    assign error_o = error_q;
`else
    logic unused_status;
    assign unused_status = full_i ^ valid_i;
    assign error_o       = 1'b0;
`endif

endmodule

// File: tb/tb_svv_traffic_gen.sv
// tb/tb_svv_traffic_gen.sv - randomized self-checking bench for svv_traffic_gen
module tb_svv_traffic_gen;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 64;
    localparam int SEED    = 'hACE1;
    localparam int MASK    = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rsn_i, start_i, full_i, valid_i;
    logic             push_o, pull_o, set_o, busy_o, done_o, error_o;
    logic [WIDTH-1:0] value_o, set_value_o;
    logic [3:0]       occupancy_o;

    logic force_bad;
    logic err_exp;
    logic cmp_en;
    int   fifo_cnt;
    int   model_wr;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        bit push;
        bit pull;
        bit set;
        int value;
        int sval;
        int occ;
        bit busy;
        bit done;
    } ent_t;

    ent_t exp_q[$];

    svv_traffic_gen #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SEED(16'hACE1)) dut (
        .clk_i       (clk),
        .rsn_i       (rsn_i),
        .start_i     (start_i),
        .full_i      (full_i),
        .valid_i     (valid_i),
        .push_o      (push_o),
        .pull_o      (pull_o),
        .set_o       (set_o),
        .value_o     (value_o),
        .set_value_o (set_value_o),
        .occupancy_o (occupancy_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    // FIFO occupancy as seen by the consumer: ops presented in a cycle land at the following edge.
    always @(posedge clk or negedge rsn_i) begin
        if (!rsn_i) fifo_cnt <= 0;
        else        fifo_cnt <= fifo_cnt + int'(push_o) - int'(pull_o);
    end

    assign valid_i = (fifo_cnt != 0) && !force_bad;
    assign full_i  = (fifo_cnt == DEPTH);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 'hFFFF;
    endfunction

    // Whole-run expectation built phase by phase from the traffic rules.
    task automatic gen_run();
        ent_t e;
        int occ = 0;
        int l = SEED;
        int c;
        bit pu, pl, st;
        for (int i = 0; i < DEPTH; i++) begin
            e = '{default: 0};
            e.push = 1; e.value = model_wr; model_wr = (model_wr + 1) & MASK;
            occ++; e.occ = occ; e.busy = 1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < DEPTH; i++) begin
            e = '{default: 0};
            e.pull = 1; occ--; e.occ = occ; e.busy = 1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < NUM_OPS; i++) begin
            e = '{default: 0};
            l = lfsr_next(l);
            c = l & 7;
            pu = c[0]; pl = c[1]; st = c[2];
            if (occ == 0) begin pl = 0; st = 0; end
            if (occ == DEPTH && !pl) pu = 0;
            if (pu) begin e.value = model_wr; model_wr = (model_wr + 1) & MASK; end
            if (st) e.sval = (~(model_wr - 1)) & MASK;
            occ = occ + int'(pu) - int'(pl);
            e.push = pu; e.pull = pl; e.set = st; e.occ = occ; e.busy = 1;
            exp_q.push_back(e);
        end
        while (occ > 0) begin
            e = '{default: 0};
            e.pull = 1; occ--; e.occ = occ; e.busy = 1;
            exp_q.push_back(e);
        end
        e = '{default: 0};
        e.busy = 1; e.done = 1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        ent_t e;
        int   ob;
        if (cmp_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = '{default: 0};
            chk("push",      32'(push_o),      32'(e.push));
            chk("pull",      32'(pull_o),      32'(e.pull));
            chk("set",       32'(set_o),       32'(e.set));
            chk("value",     32'(value_o),     e.value);
            chk("set_value", 32'(set_value_o), e.sval);
            chk("occupancy", 32'(occupancy_o), e.occ);
            chk("busy",      32'(busy_o),      32'(e.busy));
            chk("done",      32'(done_o),      32'(e.done));
            chk("error",     32'(error_o),     32'(err_exp));
            ob = int'(occupancy_o) - int'(push_o) + int'(pull_o);
            chk("inv_push_full",  32'(push_o && ob == DEPTH && !pull_o), 0);
            chk("inv_pull_empty", 32'((pull_o || set_o) && ob == 0), 0);
            chk("occ_range",      32'(int'(occupancy_o) > DEPTH), 0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 32'({push_o, pull_o, set_o, busy_o, done_o, error_o}), 0);
        chk({tag, "_value"}, 32'(value_o), 0);
        chk({tag, "_set_value"}, 32'(set_value_o), 0);
        chk({tag, "_occupancy"}, 32'(occupancy_o), 0);
    endtask

    task automatic do_run(input bit pin, input int sp1, input int sp2, input int abort_k,
                          input bit inject);
        int len;
        @(negedge clk);
        #1;
        gen_run();
        if (pin) begin
            chk("model_e0",  32'({exp_q[0].push, exp_q[0].value[7:0], exp_q[0].occ[3:0]}),  {1'b1, 8'd0, 4'd1});
            chk("model_e7",  32'({exp_q[7].push, exp_q[7].value[7:0], exp_q[7].occ[3:0]}),  {1'b1, 8'd7, 4'd8});
            chk("model_e8",  32'({exp_q[8].pull, exp_q[8].occ[3:0]}),  {1'b1, 4'd7});
            chk("model_e15", 32'({exp_q[15].pull, exp_q[15].occ[3:0]}), {1'b1, 4'd0});
            chk("model_e16", 32'({exp_q[16].set, exp_q[16].pull, exp_q[16].push, exp_q[16].value[7:0], exp_q[16].occ[3:0]}),
                {3'b001, 8'd8, 4'd1});
            chk("model_e17", 32'({exp_q[17].set, exp_q[17].pull, exp_q[17].push, exp_q[17].value[7:0],
                exp_q[17].sval[7:0], exp_q[17].occ[3:0]}), {3'b111, 8'd9, 8'hF6, 4'd1});
        end
        len = exp_q.size();
        start_i = 1'b1;
        err_exp = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            #1;
            start_i = (k == sp1 || k == sp2);
            if (k == abort_k) begin
                exp_q.delete();
                start_i = 1'b0;
                rsn_i = 1'b0;
                #2;
                chk_all_zero("async_rst");
                model_wr = 0;
                err_exp = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                rsn_i = 1'b1;
                return;
            end
            if (inject && k == 3) begin
                force_bad = 1'b1;
                @(posedge clk);
                #1;
                force_bad = 1'b0;
`ifdef SVV_TG_CHECK_EN
                err_exp = 1'b1;
`endif
            end
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rsn_i = 1'b0;
        start_i = 1'b0;
        force_bad = 1'b0;
        err_exp = 1'b0;
        cmp_en = 1'b0;
        model_wr = 0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        #1;
        rsn_i = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);

        do_run(1'b1, 3, 2 * DEPTH + $urandom_range(0, NUM_OPS - 1), -1, 1'b0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        do_run(1'b0, -1, 2 * DEPTH + $urandom_range(0, NUM_OPS - 1), -1, 1'b1);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        do_run(1'b0, -1, -1, 2 * DEPTH + $urandom_range(1, NUM_OPS - 2), 1'b0);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        do_run(1'b1, 5, 2 * DEPTH + $urandom_range(0, NUM_OPS - 1), -1, 1'b0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
